fetch_sequencer: RTL and testbench

Instruction-fetch front end for the multi-cycle processor: owns the program counter, reads 10-bit instruction words from a synchronous instruction memory, and hands each instruction (plus its immediate word for MVI) to the control unit over the `ir`/`run`/`done` handshake. It sits between the instruction ROM and the control unit, initiating every execution that the control unit responds to. It also detects HALT, supports PC loads from the datapath, and traps a control unit that never returns `done`.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/fetch_timeout.sv | 30 +++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction opcodes and the fetch sequencer state encoding.
package proc_pkg;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_MVNZ = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_PUSH = 4'b1001;
  localparam logic [3:0] OP_POP  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_IMM,
    S_IMM_WAIT,
    S_EXEC,
    S_HALT,
    S_FAULT
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [9:0] instr);
    return instr[9:6];
  endfunction

endpackage

// File: rtl/fetch_timeout.sv
// EXEC watchdog: counts cycles spent waiting for done and flags the last permitted cycle.
module fetch_timeout #(
  parameter int TIMEOUT = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, reads instruction/immediate words from a
// synchronous ROM and drives the run/done handshake with the control unit.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              go,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [9:0]        mem_rdata,
  output logic [9:0]        ir,
  output logic [9:0]        din,
  output logic              run,
  input  logic              done,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_ld_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] pc_next;
  logic              expired;
  logic              tmo_clear;
  logic              tmo_enable;

  assign tmo_clear  = (state != S_EXEC);
  assign tmo_enable = (state == S_EXEC) && !done;

  fetch_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .resetn (resetn),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(expired)
  );

  // The ROM registers its address at the edge that leaves FETCH/IMM, so mem_addr is
  // loaded on entry to those states with the PC value that will be current there.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= '0;
      mem_addr <= '0;
      ir       <= '0;
      din      <= '0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (next_state == S_FETCH || next_state == S_IMM) mem_addr <= pc_next;
      if (state == S_WAIT) ir <= mem_rdata;
      if (state == S_IMM_WAIT) din <= mem_rdata;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (go) next_state = S_FETCH;
      S_FETCH:    next_state = S_WAIT;
      S_WAIT: begin
        if (opcode_of(mem_rdata) == OP_HALT)     next_state = S_HALT;
        else if (opcode_of(mem_rdata) == OP_MVI) next_state = S_IMM;
        else                                     next_state = S_EXEC;
      end
      S_IMM:      next_state = S_IMM_WAIT;
      S_IMM_WAIT: next_state = S_EXEC;
      S_EXEC: begin
        // done is checked first so a completion on the last allowed cycle is not a fault
        if (done)         next_state = go ? S_FETCH : S_IDLE;
        else if (expired) next_state = S_FAULT;
      end
      S_HALT, S_FAULT: next_state = state;
      default:         next_state = S_IDLE;
    endcase
  end

  // PC arithmetic wraps naturally at ADDR_W bits; a datapath load beats any increment.
  always_comb begin
    pc_next = pc;
    unique case (state)
      S_WAIT, S_IMM_WAIT: pc_next = pc + 1'b1;
      S_EXEC:             if (pc_ld) pc_next = pc_ld_data;
      default:            pc_next = pc;
    endcase
  end

  // Outputs decode the state register, so they change only at clock edges.
  always_comb begin
    run    = 1'b0;
    halted = 1'b0;
    fault  = 1'b0;
    unique case (state)
      S_EXEC:  run    = 1'b1;
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM model, run/done handshake, PC loads, wrap,
// timeout, HALT and mid-EXEC reset.
module tb_fetch_sequencer;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              resetn;
  logic              go;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0]        mem_rdata;
  logic [9:0]        ir;
  logic [9:0]        din;
  logic              run;
  logic              done;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_ld_data;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;

  logic [9:0] rom [0:(1<<ADDR_W)-1];
  int tests  = 0;
  int failed = 0;

  fetch_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .go        (go),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .din       (din),
    .run       (run),
    .done      (done),
    .pc_ld     (pc_ld),
    .pc_ld_data(pc_ld_data),
    .pc        (pc),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data for the address seen at an edge is valid the following cycle.
  always @(posedge clock) mem_rdata <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts falling edges until run is seen high; a bounded wait.
  task automatic wait_run(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!run && n < 20);
    check(tag, n, exp_n);
  endtask

  task automatic finish_instr(input logic ld, input logic [ADDR_W-1:0] data);
    done       = 1'b1;
    pc_ld      = ld;
    pc_ld_data = data;
    @(negedge clock);
    done  = 1'b0;
    pc_ld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},     pc, 0);
    check({tag, "_addr"},   mem_addr, 0);
    check({tag, "_ir"},     ir, 0);
    check({tag, "_din"},    din, 0);
    check({tag, "_run"},    run, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_fault"},  fault, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 10'h000;
    rom[0]    = 10'b0000_001_010;  // MV   -> 0x00A
    rom[1]    = 10'b0010_011_100;  // ADD  -> 0x09C
    rom[2]    = 10'b0011_000_001;  // SUB  -> 0x0C1
    rom[3]    = 10'b0001_010_000;  // MVI  -> 0x050
    rom[4]    = 10'h155;
    rom[5]    = 10'b0100_001_010;  // LD   -> 0x10A
    rom[16]   = 10'b1111_000_000;  // HALT
    rom[64]   = 10'b0101_000_000;  // ST   -> 0x140
    rom[127]  = 10'b0001_011_000;  // MVI  -> 0x058, immediate wraps to rom[0]

    resetn = 1'b0; go = 1'b0; done = 1'b0; pc_ld = 1'b0; pc_ld_data = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");

    // MV at address 0: FETCH, WAIT, then run.
    resetn = 1'b1;
    go     = 1'b1;
    wait_run("mv_latency", 3);
    check("mv_ir", ir, 10'h00A);
    check("mv_pc", pc, 1);
    @(negedge clock);
    check("mv_run_held", run, 1);
    finish_instr(1'b0, '0);
    check("mv_run_drop", run, 0);
    check("mv_next_addr", mem_addr, 1);

    // Back-to-back: two idle cycles between instructions.
    wait_run("add_gap", 2);
    check("add_ir", ir, 10'h09C);
    finish_instr(1'b0, '0);
    wait_run("sub_gap", 2);
    check("sub_ir", ir, 10'h0C1);
    finish_instr(1'b0, '0);

    // MVI with immediate.
    wait_run("mvi_latency", 4);
    check("mvi_ir", ir, 10'h050);
    check("mvi_din", din, 10'h155);
    @(negedge clock);
    check("mvi_ir_hold", ir, 10'h050);
    check("mvi_din_hold", din, 10'h155);
    finish_instr(1'b0, '0);
    check("mvi_pc_after", pc, 5);
    check("mvi_next_addr", mem_addr, 5);

    // LD, then a PC load coincident with done.
    wait_run("ld_gap", 2);
    check("ld_ir", ir, 10'h10A);
    finish_instr(1'b1, 7'h40);
    check("pcld_addr", mem_addr, 7'h40);

    // pc_ld during WAIT is ignored.
    @(negedge clock);
    pc_ld      = 1'b1;
    pc_ld_data = 7'h22;
    @(negedge clock);
    pc_ld = 1'b0;
    check("wait_pcld_run", run, 1);
    check("wait_pcld_pc", pc, 7'h41);
    check("st_ir", ir, 10'h140);

    // Jump to 127 holding MVI; go drops during the fetch and must not abort it.
    finish_instr(1'b1, 7'h7F);
    check("wrap_fetch_addr", mem_addr, 7'h7F);
    go = 1'b0;
    wait_run("wrap_latency", 4);
    check("wrap_ir", ir, 10'h058);
    check("wrap_din", din, 10'h00A);
    check("wrap_pc", pc, 1);
    finish_instr(1'b0, '0);
    check("idle_run", run, 0);
    repeat (3) @(negedge clock);
    check("idle_run_stay", run, 0);
    check("idle_addr", mem_addr, 0);
    check("idle_pc", pc, 1);

    // Timeout: ADD at address 1, done withheld.
    go = 1'b1;
    wait_run("tmo_latency", 3);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!run) break;
      n++;
    end
    check("tmo_run_cycles", n, TIMEOUT);
    check("tmo_fault", fault, 1);
    check("tmo_run", run, 0);
    repeat (5) @(negedge clock);
    check("tmo_fault_sticky", fault, 1);
    check("tmo_pc_frozen", pc, 2);
    check("tmo_addr_frozen", mem_addr, 1);

    // Reset clears the fault; done on the final allowed cycle wins.
    resetn = 1'b0;
    @(negedge clock);
    check("tmo_reset_fault", fault, 0);
    resetn = 1'b1;
    wait_run("edge_latency", 3);
    repeat (TIMEOUT - 1) @(negedge clock);
    check("edge_run_still", run, 1);
    finish_instr(1'b0, '0);
    check("edge_no_fault", fault, 0);
    check("edge_run_drop", run, 0);
    check("edge_next_addr", mem_addr, 1);

    // Jump to HALT at address 16.
    wait_run("pre_halt_gap", 2);
    finish_instr(1'b1, 7'd16);
    check("halt_fetch_addr", mem_addr, 7'd16);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (run) seen = 1'b1;
    end
    check("halt_flag", halted, 1);
    check("halt_no_run", seen, 0);
    check("halt_pc", pc, 7'd17);

    // Reset out of HALT, then reset again in the middle of EXEC.
    resetn = 1'b0;
    @(negedge clock);
    check("halt_reset", halted, 0);
    resetn = 1'b1;
    wait_run("late_latency", 3);
    resetn = 1'b0;
    @(negedge clock);
    check_all_zero("mid_exec_reset");
    resetn = 1'b1;
    go     = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_idle", run, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
